// File: rtl/vga_arb_pkg.sv
// Shared types for the VGA / pixel-source SRAM arbiter: arbiter state,
// read-data owner and the read-return tag carried alongside SRAM reads.
package vga_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_VGA  = 2'd1,
    ARB_SRC  = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_VGA = 1'b0,
    OWN_SRC = 1'b1
  } owner_t;

  typedef struct packed {
    logic   valid;
    owner_t owner;
  } tag_t;

  localparam tag_t TAG_NONE = '{valid: 1'b0, owner: OWN_VGA};

  // Owner of the command currently on the SRAM bus, from the last-grant state.
  function automatic owner_t owner_of(input arb_state_t st);
    return (st == ARB_SRC) ? OWN_SRC : OWN_VGA;
  endfunction

endpackage

// File: rtl/vga_sram_rd_tag_pipe.sv
// DEPTH-stage shift register of read-return tags; the output stage lines up
// with the cycle in which the SRAM presents the matching read data.
module vga_sram_rd_tag_pipe
  import vga_arb_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  tag_t tag_i,
  output tag_t tag_o
);

  tag_t [DEPTH-1:0] pipe_q;

  // NOTE: every stage is reset so that in-flight tags cannot produce a late valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_q <= '0;
    end else begin
      pipe_q[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign tag_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/vga_sram_arbiter.sv
// Single-port SRAM arbiter: VGA prefetch reads win, except that a source
// request denied SRC_MAX_WAIT times in a row is forced through.
module vga_sram_arbiter
  import vga_arb_pkg::*;
#(
  parameter int AVN_AW       = 18,
  parameter int AVN_DW       = 16,
  parameter int RD_LAT       = 1,
  parameter int SRC_MAX_WAIT = 8
) (
  input  logic                sys_clk,
  input  logic                sys_rst,

  input  logic                vga_req,
  input  logic [AVN_AW-1:0]   vga_addr,
  output logic                vga_gnt,
  output logic                vga_rdata_vld,
  output logic [AVN_DW-1:0]   vga_rdata,

  input  logic                src_avn_read,
  input  logic                src_avn_write,
  input  logic [AVN_AW-1:0]   src_avn_address,
  input  logic [AVN_DW-1:0]   src_avn_writedata,
  input  logic [AVN_DW/8-1:0] src_avn_byteenable,
  output logic                src_avn_waitrequest,
  output logic [AVN_DW-1:0]   src_avn_readdata,
  output logic                src_avn_readdatavalid,
  output logic                src_err,

  output logic                sram_avn_read,
  output logic                sram_avn_write,
  output logic [AVN_AW-1:0]   sram_avn_address,
  output logic [AVN_DW-1:0]   sram_avn_writedata,
  output logic [AVN_DW/8-1:0] sram_avn_byteenable,
  input  logic [AVN_DW-1:0]   sram_avn_readdata
);

  localparam int         BE_W     = AVN_DW / 8;
  localparam logic [7:0] MAX_WAIT = 8'(SRC_MAX_WAIT);

  arb_state_t          state_q, state_d;
  logic [7:0]          starve_q, starve_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;
  logic [AVN_AW-1:0]   addr_q, addr_d;
  logic [AVN_DW-1:0]   wdata_q, wdata_d;
  logic [BE_W-1:0]     be_q, be_d;
  logic                err_q, err_d;

  logic                src_req;
  logic                src_gnt;
  logic                vga_gnt_c;
  tag_t                tag_in;
  tag_t                tag_out;

  assign src_req = src_avn_read | src_avn_write;

  // Grants are forced low while reset is held so no requester sees acceptance.
  always_comb begin
    src_gnt   = 1'b0;
    vga_gnt_c = 1'b0;
    if (sys_rst) begin
      if (src_req && (starve_q == MAX_WAIT)) begin
        src_gnt = 1'b1;
      end else if (vga_req) begin
        vga_gnt_c = 1'b1;
      end else if (src_req) begin
        src_gnt = 1'b1;
      end
    end
  end

  // NOTE: every variable gets its hold/default value first, so no latch is inferred.
  always_comb begin
    state_d  = ARB_IDLE;
    rd_d     = 1'b0;
    wr_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    err_d    = err_q;
    starve_d = starve_q;

    if (src_gnt) begin
      state_d = ARB_SRC;
      wr_d    = src_avn_write;
      rd_d    = src_avn_read & ~src_avn_write;
      addr_d  = src_avn_address;
      wdata_d = src_avn_writedata;
      be_d    = src_avn_byteenable;
      err_d   = err_q | (src_avn_read & src_avn_write);
    end else if (vga_gnt_c) begin
      state_d = ARB_VGA;
      rd_d    = 1'b1;
      addr_d  = vga_addr;
      be_d    = '1;
    end

    if (!src_req || src_gnt) begin
      starve_d = '0;
    end else if (starve_q != MAX_WAIT) begin
      starve_d = starve_q + 8'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q  <= ARB_IDLE;
      starve_q <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      err_q    <= err_d;
    end
  end

  // The tag enters alongside the command on the bus, so RD_LAT stages suffice.
  always_comb begin
    tag_in       = TAG_NONE;
    tag_in.valid = rd_q;
    tag_in.owner = owner_of(state_q);
  end

  vga_sram_rd_tag_pipe #(
    .DEPTH (RD_LAT)
  ) u_tag_pipe (
    .clk   (sys_clk),
    .rst_n (sys_rst),
    .tag_i (tag_in),
    .tag_o (tag_out)
  );

  assign vga_gnt               = vga_gnt_c;
  assign src_avn_waitrequest   = ~src_gnt;
  assign src_err               = err_q;

  assign sram_avn_read         = rd_q;
  assign sram_avn_write        = wr_q;
  assign sram_avn_address      = addr_q;
  assign sram_avn_writedata    = wdata_q;
  assign sram_avn_byteenable   = be_q;

  assign vga_rdata             = sram_avn_readdata;
  assign src_avn_readdata      = sram_avn_readdata;
  assign vga_rdata_vld         = tag_out.valid & (tag_out.owner == OWN_VGA);
  assign src_avn_readdatavalid = tag_out.valid & (tag_out.owner == OWN_SRC);

endmodule

// File: doc/vga_sram_arbiter.md
Name: vga_sram_arbiter

Overview:
- Schedules one single-port SRAM (Avalon-MM) between two requesters in the sys_clk domain: the VGA prefetch reader (stream of frame-buffer reads) and the pixel-generation source port (read/write).
- VGA reads have priority. A starvation counter guarantees the source port one slot after a bounded wait.
- SRAM commands are registered. Returning read data is tagged and routed to its owner.
- Sits between the frame-buffer prefetch FIFO write side and the external SRAM controller.

Parameters:
- AVN_AW, 18, SRAM word-address width.
- AVN_DW, 16, SRAM data width; must be a multiple of 8.
- RD_LAT, 1, SRAM read latency in cycles from command to readdata; legal range 1..4.
- SRC_MAX_WAIT, 8, maximum consecutive denied cycles for a pending source request before forced grant; legal range 1..255.

Ports:
- sys_clk  in  1  system clock.
- sys_rst  in  1  asynchronous, active-low reset.
- vga_req  in  1  VGA read request.
- vga_addr  in  AVN_AW  VGA read address.
- vga_gnt  out  1  combinational; VGA request accepted this cycle.
- vga_rdata_vld  out  1  VGA read data valid.
- vga_rdata  out  AVN_DW  VGA read data.
- src_avn_read  in  1  source read.
- src_avn_write  in  1  source write.
- src_avn_address  in  AVN_AW  source address.
- src_avn_writedata  in  AVN_DW  source write data.
- src_avn_byteenable  in  AVN_DW/8  source byte enables.
- src_avn_waitrequest  out  1  combinational; equals ~src_gnt.
- src_avn_readdata  out  AVN_DW  source read data.
- src_avn_readdatavalid  out  1  source read data valid.
- src_err  out  1  sticky protocol-error flag.
- sram_avn_read  out  1  registered SRAM read.
- sram_avn_write  out  1  registered SRAM write.
- sram_avn_address  out  AVN_AW  registered SRAM address.
- sram_avn_writedata  out  AVN_DW  registered SRAM write data.
- sram_avn_byteenable  out  AVN_DW/8  registered SRAM byte enables.
- sram_avn_readdata  in  AVN_DW  SRAM read data.

Behaviour:
- Reset (sys_rst=0, async): all sram_avn_* outputs = 0, vga_rdata_vld = 0, src_avn_readdatavalid = 0, src_err = 0, starve_cnt = 0, tag pipe cleared, FSM = ARB_IDLE. While in reset src_avn_waitrequest = 1 and vga_gnt = 0.
- src_req = src_avn_read | src_avn_write.
- Per-cycle grant, evaluated in priority order:
  - (1) src_req and starve_cnt == SRC_MAX_WAIT: grant src.
  - (2) else vga_req: grant vga.
  - (3) else src_req: grant src.
  - (4) else none.
- FSM records the owner of the last grant: ARB_IDLE, ARB_VGA, ARB_SRC. Next state = owner of the current grant, or ARB_IDLE if none. The FSM feeds only the tag pipe and debug; it does not bias arbitration.
- starve_cnt (8 bit):
  - Clears on src grant or when src_req = 0.
  - Otherwise increments when src_req is denied.
  - Saturates at SRC_MAX_WAIT.
- Command timing: grant in cycle t ⇒ sram_avn_* carries the command in cycle t+1. With no grant, sram_avn_read/write = 0 in t+1; address, data and byteenable hold their previous values.
- VGA commands always drive byteenable all-ones and write = 0.
- Read return: a read command in cycle t+1 returns data in cycle t+1+RD_LAT.
  - A RD_LAT-deep tag pipe (valid, owner) drives the valid outputs.
  - vga_rdata_vld or src_avn_readdatavalid asserts in exactly that cycle.
  - Data passes through combinationally from sram_avn_readdata to both *_rdata outputs.
  - Writes push an invalid tag.
- Back-to-back grants of mixed owners are legal every cycle. Returns are in order with no bubbles.
- Simultaneous src_avn_read and src_avn_write: the write is issued, the read is dropped, and src_err sets and stays set until reset.
- Reset mid-operation: in-flight tags are discarded and no late valid is produced after reset deassertion.

Decomposition:
- Shared package vga_arb_pkg:
  - arb_state_t enum {ARB_IDLE, ARB_VGA, ARB_SRC}.
  - owner_t enum {OWN_VGA, OWN_SRC}.
  - tag struct {valid, owner}.
- One sub-module, vga_sram_rd_tag_pipe: a parameterised RD_LAT-stage shift register of tags with async active-low reset.

Test Plan:
- Reset: assert sys_rst=0 with requests active → all registered outputs 0, src_avn_waitrequest=1, no valid pulses; release → first grant on the next cycle.
- VGA only: vga_req held high for 16 cycles, addresses 0..15, RD_LAT=1 → vga_gnt=1 every cycle, sram_avn_address=0..15 one cycle later, vga_rdata_vld 2 cycles after each grant, 16 pulses in total.
- Source only: write 0x0ABC to address 0x100, then read 0x100 → waitrequest low on both; write command has byteenable passed through; readdatavalid 2 cycles after the read grant with data 0x0ABC.
- Starvation: SRC_MAX_WAIT=4, vga_req held high, src read pending → src denied 4 cycles, granted on the 5th, VGA resumes the next cycle, starve_cnt=0.
- Error: src_avn_read=src_avn_write=1 → write issued, no readdatavalid, src_err=1 sticky until reset.
- Reset mid-read: RD_LAT=3, reset asserted 1 cycle after a VGA read grant → no vga_rdata_vld at any later cycle.
